// File: rtl/obf_igu_pipe.sv
// Instruction group unit: classifies OR1200 words into an index, buffers them in a
// small valid/ready FIFO and keeps saturating accept/unknown counters.
module obf_igu_pipe #(
    parameter int IDX_W = 7,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_insn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_unk,
    output logic [31:0]      out_insn,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_insn,
    output logic [CNT_W-1:0] cnt_unk
);
    // Handshake: a word moves on any cycle where valid && ready; in_ready and
    // out_valid depend only on registered pointers, never on the opposite side.
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [IDX_W-1:0] mem_idx  [DEPTH];
    logic             mem_unk  [DEPTH];
    logic [31:0]      mem_insn [DEPTH];

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = in_valid && !full;
    assign pop   = out_ready && !empty;

    logic [5:0] op;
    logic [4:0] k;
    logic [7:0] s;
    logic [3:0] lo;
    logic [3:0] koff;
    logic       kok;
    logic [6:0] code;
    logic       dec_unk;
    logic [IDX_W-1:0] dec_idx;

    assign op = in_insn[31:26];
    assign k  = in_insn[25:21];
    assign s  = {in_insn[9:6], in_insn[3:0]};
    assign lo = in_insn[3:0];

    // Shared sub-op map of ops 0x2F and 0x39: k 0..5 -> 0..5, k 10..13 -> 6..9.
    always_comb begin
        kok  = 1'b1;
        koff = 4'd0;
        if (k <= 5'd5) begin
            koff = k[3:0];
        end else if (k >= 5'd10 && k <= 5'd13) begin
            koff = 4'(k - 5'd4);
        end else begin
            kok = 1'b0;
        end
    end

    always_comb begin
        code    = 7'd0;
        dec_unk = 1'b0;
        case (op)
            6'h00: code = 7'd0;
            6'h01: code = 7'd1;
            6'h03: code = 7'd2;
            6'h04: code = 7'd3;
            6'h05: code = 7'd4;
            6'h06: code = in_insn[16] ? 7'd5 : 7'd6;
            6'h08: begin
                case (in_insn[25:23])
                    3'b000:  code = 7'd7;
                    3'b010:  code = 7'd8;
                    3'b100:  code = 7'd9;
                    3'b101:  code = 7'd10;
                    3'b110:  code = 7'd11;
                    default: dec_unk = 1'b1;
                endcase
            end
            6'h09: code = 7'd12;
            6'h11: code = 7'd13;
            6'h12: code = 7'd14;
            6'h13: code = 7'd15;
            6'h1C, 6'h1D, 6'h1E, 6'h1F,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
            6'h27, 6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D:
                code = {1'b0, op} - 7'd12;
            6'h2E: code = 7'd34 + {5'd0, in_insn[7:6]};
            6'h2F: begin
                if (kok) code = 7'd38 + {3'd0, koff};
                else     dec_unk = 1'b1;
            end
            6'h30: code = 7'd48;
            6'h31: begin
                case (lo)
                    4'h1:    code = 7'd49;
                    4'h3:    code = 7'd50;
                    4'h2:    code = 7'd51;
                    4'h4:    code = 7'd52;
                    default: dec_unk = 1'b1;
                endcase
            end
            6'h33, 6'h34, 6'h35, 6'h36, 6'h37:
                code = {1'b0, op} + 7'd2;
            6'h38: begin
                // Exact selector matches take precedence over the field-based groups.
                case (s)
                    8'h0C: code = 7'd58;
                    8'h0D: code = 7'd59;
                    8'h1C: code = 7'd60;
                    8'h1D: code = 7'd61;
                    8'h2C: code = 7'd62;
                    8'h3C: code = 7'd63;
                    8'h08: code = 7'd72;
                    8'h18: code = 7'd73;
                    8'h28: code = 7'd74;
                    8'h38: code = 7'd75;
                    default: begin
                        if (in_insn[9:8] == 2'b00 && lo <= 4'd5) begin
                            code = 7'd64 + {3'd0, lo};
                        end else if (in_insn[9:8] == 2'b00 && lo == 4'hE) begin
                            code = 7'd70;
                        end else if (in_insn[9:8] == 2'b00 && lo == 4'hF) begin
                            code = 7'd71;
                        end else if (in_insn[9:8] == 2'b01 && lo == 4'hF) begin
                            code = 7'd76;
                        end else if (in_insn[9:8] == 2'b11) begin
                            case (lo)
                                4'h6:    code = 7'd77;
                                4'h7:    code = 7'd78;
                                4'h9:    code = 7'd79;
                                4'hA:    code = 7'd80;
                                4'hB:    code = 7'd81;
                                4'hC:    code = 7'd82;
                                default: dec_unk = 1'b1;
                            endcase
                        end else begin
                            dec_unk = 1'b1;
                        end
                    end
                endcase
            end
            6'h39: begin
                if (kok) code = 7'd83 + {3'd0, koff};
                else     dec_unk = 1'b1;
            end
            6'h3C, 6'h3D, 6'h3E, 6'h3F:
                code = {1'b0, op} + 7'd33;
            default: dec_unk = 1'b1;
        endcase
    end

    assign dec_idx = dec_unk ? '1 : IDX_W'(code);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_idx[wr_ptr[AW-1:0]]  <= dec_idx;
            mem_unk[wr_ptr[AW-1:0]]  <= dec_unk;
            mem_insn[wr_ptr[AW-1:0]] <= in_insn;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_insn <= '0;
            cnt_unk  <= '0;
        end else if (cnt_clr) begin
            cnt_insn <= '0;
            cnt_unk  <= '0;
        end else if (push) begin
            if (cnt_insn != CNT_MAX) cnt_insn <= cnt_insn + 1'b1;
            if (dec_unk && cnt_unk != CNT_MAX) cnt_unk <= cnt_unk + 1'b1;
        end
    end

    // Head fields read as zero whenever the FIFO is empty, including after reset.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_idx   = empty ? '0    : mem_idx[rd_ptr[AW-1:0]];
    assign out_unk   = empty ? 1'b0  : mem_unk[rd_ptr[AW-1:0]];
    assign out_insn  = empty ? 32'd0 : mem_insn[rd_ptr[AW-1:0]];

endmodule
